// File: rtl/roc_tick_scheduler.sv
// Tick sequencer for the RoC fabric: rate accumulator, run/pause/step, settle window, snapshot arbitration.
// States: S_PAUSED idle, step only | S_RUN ticking at r_tps | S_SETTLE fabric settling after a tick.
module roc_tick_scheduler #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned TICK_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_tps,
  input  logic        i_tps_load,
  input  logic        i_step,
  input  logic        i_capture_req,
  input  logic        i_count_clr,
  output logic        o_tick,
  output logic        o_roc_en,
  output logic        o_busy,
  output logic        o_capture_ack,
  output logic [31:0] o_tick_count,
  output logic        o_overrun
);
  localparam int unsigned   CW          = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(TICK_CYCLES - 1);
  localparam logic [32:0]   HZ          = 33'(CLK_HZ);

  typedef enum logic [1:0] {S_PAUSED, S_RUN, S_SETTLE} state_t;

  state_t        state;
  logic [31:0]   r_tps;
  logic [32:0]   acc;
  logic          pending;
  logic [CW-1:0] settle_cnt;
  logic          cap_armed;

  logic [32:0] acc_sum, acc_upd;
  logic        accum, due, decide, grant;
  logic [1:0]  backlog;
  logic [31:0] tps_clamp, tps_nxt, count_inc;

  always_comb begin
    accum     = (r_tps != '0) && (state != S_PAUSED);
    acc_sum   = acc + {1'b0, r_tps};
    due       = accum && (acc_sum >= HZ);
    acc_upd   = acc;
    if (accum) acc_upd = due ? (acc_sum - HZ) : acc_sum;
    // the last settle cycle already arbitrates, so a waiting capture is acked the first free cycle
    decide    = (state == S_PAUSED) || (state == S_RUN) ||
                ((state == S_SETTLE) && (settle_cnt == '0));
    grant     = i_capture_req && cap_armed && decide;
    backlog   = {1'b0, pending} + {1'b0, due};
    tps_clamp = (i_tps > 32'(CLK_HZ)) ? 32'(CLK_HZ) : i_tps;
    tps_nxt   = i_tps_load ? tps_clamp : r_tps;
    count_inc = i_count_clr ? 32'd1 : (o_tick_count + 32'd1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_PAUSED;
      r_tps         <= '0;
      acc           <= '0;
      pending       <= 1'b0;
      settle_cnt    <= '0;
      cap_armed     <= 1'b0;
      o_tick        <= 1'b0;
      o_roc_en      <= 1'b0;
      o_busy        <= 1'b0;
      o_capture_ack <= 1'b0;
      o_tick_count  <= '0;
      o_overrun     <= 1'b0;
    end else begin
      o_tick        <= 1'b0;
      o_busy        <= 1'b0;
      o_capture_ack <= grant;
      o_roc_en      <= (tps_nxt != '0);
      acc           <= acc_upd;
      if (grant) cap_armed <= 1'b0;
      else if (!i_capture_req) cap_armed <= 1'b1;
      if (i_count_clr) o_tick_count <= '0;

      case (state)
        S_PAUSED: begin
          if (i_step && !grant) begin
            o_tick       <= 1'b1;
            o_tick_count <= count_inc;
            settle_cnt   <= SETTLE_LAST;
            state        <= S_SETTLE;
          end else if (r_tps != '0) begin
            state <= S_RUN;
          end
        end
        default: begin
          if ((state == S_SETTLE) && (settle_cnt != '0)) begin
            settle_cnt <= settle_cnt - CW'(1);
            o_busy     <= 1'b1;
            if (due) begin
              if (pending) o_overrun <= 1'b1;
              else pending <= 1'b1;
            end
          end else if (r_tps == '0) begin
            state   <= S_PAUSED;
            pending <= 1'b0;
          end else begin
            state <= S_RUN;
            if (backlog != 2'd0) begin
              if (grant) begin
                pending <= 1'b1;
                if (backlog[1]) o_overrun <= 1'b1;
              end else begin
                o_tick       <= 1'b1;
                o_tick_count <= count_inc;
                settle_cnt   <= SETTLE_LAST;
                state        <= S_SETTLE;
                pending      <= backlog[1];
              end
            end
          end
        end
      endcase

      if (i_tps_load) begin
        r_tps     <= tps_clamp;
        acc       <= '0;
        pending   <= 1'b0;
        o_overrun <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_roc_tick_scheduler.sv
// Bench for roc_tick_scheduler at CLK_HZ=100, TICK_CYCLES=4: rate table plus capture/step/reset sequences.
module tb_roc_tick_scheduler;
  localparam int unsigned CLK_HZ      = 100;
  localparam int unsigned TICK_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] tps = '0;
  logic        tps_load = 1'b0, step = 1'b0, capture_req = 1'b0, count_clr = 1'b0;
  logic        tick, roc_en, busy, capture_ack, overrun;
  logic [31:0] tick_count;

  always #5 clk = ~clk;

  roc_tick_scheduler #(.CLK_HZ(CLK_HZ), .TICK_CYCLES(TICK_CYCLES)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tps(tps), .i_tps_load(tps_load), .i_step(step),
    .i_capture_req(capture_req), .i_count_clr(count_clr), .o_tick(tick), .o_roc_en(roc_en),
    .o_busy(busy), .o_capture_ack(capture_ack), .o_tick_count(tick_count), .o_overrun(overrun)
  );

  typedef struct { string name; int val; } exp_t;
  typedef struct { int tps; int n; int period; int ovr; } vec_t;

  exp_t exp_q[$];
  vec_t vecs[6];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic push_exp(input string name, input int v);
    exp_t e;
    e.name = name;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input int act);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk(e.name, act, e.val);
    end
  endtask

  task automatic wait_tick(input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tick) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, int'(ok), 1);
  endtask

  task automatic measure(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 64);
  endtask

  task automatic pulse_load(input int v);
    tps      = v;
    tps_load = 1'b1;
    @(negedge clk);
    tps_load = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int m, seen;
    vecs[0] = '{10,  5, 10, 0};
    vecs[1] = '{50,  6,  4, 1};
    vecs[2] = '{10,  5, 10, 0};
    vecs[3] = '{20,  5,  5, 0};
    vecs[4] = '{25,  5,  4, 0};
    vecs[5] = '{200, 5,  4, 1};

    repeat (2) @(negedge clk);
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_roc_en", roc_en, 0);
    chk("rst_ack", capture_ack, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_count", int'(tick_count), 0);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin @(negedge clk); seen += int'(tick); end
    chk("idle_ticks", seen, 0);
    chk("idle_roc_en", roc_en, 0);

    // rate table: skip two ticks so the phase is settled, then time each interval
    foreach (vecs[v]) begin
      for (int k = 0; k < vecs[v].n; k++)
        push_exp($sformatf("period_tps%0d", vecs[v].tps), vecs[v].period);
      pulse_load(vecs[v].tps);
      wait_tick(300, "first_tick");
      wait_tick(300, "second_tick");
      for (int k = 0; k < vecs[v].n; k++) begin
        measure(m);
        pop_chk(m);
      end
      chk($sformatf("overrun_tps%0d", vecs[v].tps), overrun, vecs[v].ovr);
      chk($sformatf("roc_en_tps%0d", vecs[v].tps), roc_en, 1);
    end

    // count: clear coincident with a tick yields 1, then 100 ticks per 1000 cycles
    pulse_load(10);
    wait_tick(300, "cnt_first_tick");
    wait_tick(300, "cnt_second_tick");
    repeat (9) @(negedge clk);
    count_clr = 1'b1;
    @(negedge clk);
    count_clr = 1'b0;
    chk("clr_coincide_tick", tick, 1);
    chk("clr_coincide_count", int'(tick_count), 1);
    repeat (1000) @(negedge clk);
    chk("cnt1000_tick", tick, 1);
    chk("cnt1000_count", int'(tick_count), 101);
    chk("cnt1000_overrun", overrun, 0);

    // capture coincident with a due tick in RUN: ack first, tick deferred one cycle
    repeat (9) @(negedge clk);
    capture_req = 1'b1;
    @(negedge clk);
    chk("cap_run_ack", capture_ack, 1);
    chk("cap_run_no_tick", tick, 0);
    @(negedge clk);
    chk("cap_run_deferred_tick", tick, 1);
    chk("cap_run_no_reack", capture_ack, 0);
    @(negedge clk);
    chk("cap_run_held_no_reack", capture_ack, 0);
    capture_req = 1'b0;
    repeat (8) @(negedge clk);
    chk("cap_run_next_tick", tick, 1);
    chk("cap_run_count", int'(tick_count), 103);

    // capture requested inside settle: ack on the first free cycle, no tick lost
    pulse_load(25);
    wait_tick(300, "cap_set_first_tick");
    wait_tick(300, "cap_set_second_tick");
    count_clr = 1'b1;
    @(negedge clk);
    count_clr = 1'b0;
    chk("cap_set_count_clr", int'(tick_count), 0);
    capture_req = 1'b1;
    @(negedge clk);
    chk("cap_set_ack_wait1", capture_ack, 0);
    chk("cap_set_busy1", busy, 1);
    @(negedge clk);
    chk("cap_set_ack_wait2", capture_ack, 0);
    @(negedge clk);
    chk("cap_set_ack", capture_ack, 1);
    chk("cap_set_ack_no_tick", tick, 0);
    chk("cap_set_ack_not_busy", busy, 0);
    capture_req = 1'b0;
    @(negedge clk);
    chk("cap_set_deferred_tick", tick, 1);
    repeat (40) @(negedge clk);
    chk("cap_set_tick_t45", tick, 1);
    chk("cap_set_count", int'(tick_count), 11);
    chk("cap_set_overrun", overrun, 0);

    // load 0 during settle: settle runs to completion, then paused for good
    @(negedge clk);
    tps = 0;
    tps_load = 1'b1;
    @(negedge clk);
    tps_load = 1'b0;
    chk("stop_busy_kept1", busy, 1);
    @(negedge clk);
    chk("stop_busy_kept2", busy, 1);
    @(negedge clk);
    chk("stop_busy_done", busy, 0);
    chk("stop_roc_en", roc_en, 0);
    count_clr = 1'b1;
    @(negedge clk);
    count_clr = 1'b0;
    seen = 0;
    repeat (500) begin @(negedge clk); seen += int'(tick); end
    chk("stop_ticks500", seen, 0);
    chk("stop_count", int'(tick_count), 0);

    // single step from pause; a second step inside settle is ignored
    push_exp("step_ticks", 1);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    seen = int'(tick);
    chk("step_tick", tick, 1);
    chk("step_count", int'(tick_count), 1);
    chk("step_tick_not_busy", busy, 0);
    @(negedge clk);
    chk("step_busy1", busy, 1);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    seen += int'(tick);
    chk("step_busy2", busy, 1);
    @(negedge clk);
    seen += int'(tick);
    chk("step_busy3", busy, 1);
    @(negedge clk);
    seen += int'(tick);
    chk("step_busy_end", busy, 0);
    repeat (10) begin @(negedge clk); seen += int'(tick); end
    pop_chk(seen);
    chk("step_count_final", int'(tick_count), 1);

    // asynchronous reset in the middle of a settle
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("rst_mid_tick", tick, 1);
    @(negedge clk);
    chk("rst_mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_count", int'(tick_count), 0);
    chk("rst_mid_tick_low", tick, 0);
    chk("rst_mid_roc_en", roc_en, 0);
    chk("rst_mid_ack", capture_ack, 0);
    chk("rst_mid_overrun", overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (50) begin @(negedge clk); seen += int'(tick); end
    chk("rst_mid_no_tick", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
